// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the instruction/data memory request arbiter.
package mem_req_arbiter_pkg;

    // Requester identity, also stored in the order FIFO.
    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    // Access size encodings on the SRAM-like interface.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Grant FSM: IDLE arbitrates, HOLD_x pins the selection until acceptance.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } grant_state_t;

endpackage

// File: rtl/mem_req_arbiter_req_order_fifo.sv
// In-order tracking of outstanding transactions: one id bit per accepted request.
module req_order_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == {CNT_W{1'b0}});
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;
    assign dout      = r_mem[r_rptr];

    // Storage, pointers (wrap naturally since DEPTH is a power of 2) and occupancy.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 1'b0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wptr] <= din;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access,
// keeping returned data routed to the requester that issued it.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int MAX_OUTST = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    grant_state_t r_state;
    logic         w_sel;
    logic         w_sel_req;
    logic         w_accept;
    logic         w_full;
    logic         w_empty;
    logic         w_head;
    logic         w_pop;

    // Source selection: fixed data priority in IDLE, pinned source while holding.
    always_comb begin
        w_sel     = SRC_INST;
        w_sel_req = 1'b0;
        case (r_state)
            IDLE: begin
                if (data_req) begin
                    w_sel     = SRC_DATA;
                    w_sel_req = 1'b1;
                end else begin
                    w_sel     = SRC_INST;
                    w_sel_req = inst_req;
                end
            end
            HOLD_D: begin
                w_sel     = SRC_DATA;
                w_sel_req = data_req;
            end
            HOLD_I: begin
                w_sel     = SRC_INST;
                w_sel_req = inst_req;
            end
            default: begin
                w_sel     = SRC_INST;
                w_sel_req = 1'b0;
            end
        endcase
    end

    // Full comes from the registered count, so a same-cycle pop cannot unblock issue.
    assign mem_req  = w_sel_req & ~w_full;
    assign w_accept = mem_req & mem_addr_ok;

    // Address-phase mux; everything reads zero when nobody is requesting.
    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'b00;
        mem_wstrb = 4'b0000;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (!w_sel_req) begin
            mem_wr = 1'b0;
        end else if (w_sel == SRC_DATA) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else begin
            mem_size  = inst_size;
            mem_addr  = inst_addr;
        end
    end

    assign data_addr_ok = w_accept & (w_sel == SRC_DATA);
    assign inst_addr_ok = w_accept & (w_sel == SRC_INST);

    // Grant FSM: enter HOLD when an issued request is stalled, leave on accept or cancel.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mem_req && !mem_addr_ok) begin
                        r_state <= (w_sel == SRC_DATA) ? HOLD_D : HOLD_I;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                HOLD_D, HOLD_I: begin
                    if (w_accept || !w_sel_req) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= r_state;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_pop = mem_data_ok & ~w_empty;

    req_order_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (w_accept),
        .pop    (w_pop),
        .din    (w_sel),
        .dout   (w_head),
        .full   (w_full),
        .empty  (w_empty)
    );

    // Return routing by the id at the FIFO head; read data is broadcast.
    assign inst_data_ok = w_pop & (w_head == SRC_INST);
    assign data_data_ok = w_pop & (w_head == SRC_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester and the data requester. The data requester is the EX stage's data_sram interface.
- Arbitrates address phases and holds the granted request stable until addr_ok.
- Tracks outstanding transactions in order and routes each data_ok/rdata back to the requester that issued it.
- Sits between the pipeline core and the memory bridge.

Parameters:
- MAX_OUTST, 4, maximum accepted-but-unfinished transactions (power of 2, >=2)
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- inst_req  in  1  fetch request (read only)
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch address accepted
- inst_data_ok  out  1  fetch data returned
- inst_rdata  out  DATA_W  fetch read data
- data_req  in  1  data request
- data_wr  in  1  1=store
- data_size  in  2  access size
- data_wstrb  in  4  byte strobes
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  load data / store completion
- data_rdata  out  DATA_W  load data
- mem_req  out  1  to memory: request
- mem_wr  out  1  to memory: write
- mem_size  out  2  to memory: size
- mem_wstrb  out  4  to memory: strobes
- mem_addr  out  ADDR_W  to memory: address
- mem_wdata  out  DATA_W  to memory: write data
- mem_addr_ok  in  1  memory accepted address
- mem_data_ok  in  1  memory returned data / write done
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset: resetn sampled at posedge clk (synchronous, active-low); clock clk.
  - Grant FSM goes to IDLE; FIFO is emptied (count=0, pointers=0).
  - All outputs are 0 while no requester is active.
- Grant FSM states:
  - IDLE: select data if data_req, else inst if inst_req (fixed data priority).
  - HOLD_D / HOLD_I: the selected source stays forced until acceptance.
- Transitions:
  - IDLE->HOLD_D/HOLD_I: when mem_req=1 & mem_addr_ok=0 for the selected source.
  - HOLD_x->IDLE: on mem_addr_ok=1, or if the held requester drops req (treated as cancel; no push).
  - IDLE stays IDLE: when the request is accepted in the same cycle.
- Issue path (combinational, 0 cycles):
  - mem_req = sel_req & ~full.
  - mem_wr/size/wstrb/addr/wdata are muxed from the selected source. The inst source drives mem_wr=0, mem_wstrb=0, mem_wdata=0.
  - x_addr_ok = mem_addr_ok & mem_req & (sel==x).
  - The non-selected requester sees addr_ok=0.
- Full handling: full is computed from the registered count. A pop in the same cycle does not unblock issue (no bypass).
- Order FIFO (depth MAX_OUTST, 1-bit id: 0=inst, 1=data):
  - Push: on mem_req & mem_addr_ok.
  - Pop: on mem_data_ok & ~empty.
  - Simultaneous push+pop: count unchanged, both pointers advance.
  - Pointers wrap modulo MAX_OUTST.
- Return routing (combinational):
  - inst_data_ok = mem_data_ok & ~empty & head==0.
  - data_data_ok = mem_data_ok & ~empty & head==1.
  - inst_rdata = data_rdata = mem_rdata (unqualified).
- Boundary cases:
  - mem_data_ok while empty: ignored; no data_ok asserted, no pop.
  - Data and inst both requesting in IDLE: data wins; inst waits.
  - Data keeps requesting: inst may starve. This is accepted; the pipeline bounds data requests.
  - Stores occupy FIFO slots like loads, because completion is signalled by data_ok.
  - Reset mid-transaction: all tracking is dropped. Memory must also be reset.

Decomposition:
- Shared package holds:
  - SRC_INST=1'b0, SRC_DATA=1'b1.
  - Grant FSM encoding: IDLE, HOLD_I, HOLD_D.
  - Size encodings: SZ_B, SZ_H, SZ_W.
- Sub-module req_order_fifo holds the synchronous 1-bit-wide FIFO of depth MAX_OUTST:
  - Inputs: push, pop, din.
  - Outputs: dout, full, empty.
  - Storage is registers; it contains no combinational read-to-write path.

Test Plan:
- Data read, addr 0x1c000100, addr_ok same cycle -> data_addr_ok=1 in cycle 0; FIFO count=1; two cycles later mem_data_ok with rdata 0xdeadbeef -> data_data_ok=1, data_rdata=0xdeadbeef, inst_data_ok=0.
- inst_req and data_req together, mem_addr_ok held 0 for 3 cycles -> FSM in HOLD_D; mem_addr=data_addr throughout; inst_addr_ok=0. On accept, inst is issued next cycle.
- Interleaved sequence inst, data-store, inst accepted back-to-back, then 3 mem_data_ok -> data_ok order is inst, data, inst; store gets data_data_ok; mem_wstrb=4'b0011 passed through for the half store at addr 0x...0.
- Issue 4 accepted reads with no returns (MAX_OUTST=4) -> 5th request sees mem_req=0. A cycle with mem_data_ok still blocks issue; the next cycle issues.
- Spurious mem_data_ok with empty FIFO -> no data_ok on either port; count stays 0.
- resetn=0 for one cycle with 2 outstanding -> FIFO empty, FSM IDLE. A subsequent mem_data_ok is ignored.
